// File: rtl/ram_cmd_ctrl.sv
// Command decoder in front of a single-port byte RAM: 00 wr addr, 01 wr data, 10 rd addr, 11 rd data.
// Read data and tx_valid follow a serviced 11 by one clock. Define RAM_AUTOINC_EN to post-increment addresses.
module ram_cmd_ctrl #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] din,
    input  logic       rx_valid,
    output logic [7:0] dout,
    output logic       tx_valid,
    output logic       cmd_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RADDR = 2'd1,
        RDATA = 2'd2
    } rd_state_t;

    rd_state_t              state;
    rd_state_t              state_nxt;
    logic [7:0]             mem [MEM_DEPTH];
    logic [ADDR_SIZE-1:0]   wr_addr;
    logic [ADDR_SIZE-1:0]   rd_addr;
    logic                   wr_armed;

    logic [1:0] op;
    logic       do_waddr;
    logic       do_wdata;
    logic       do_raddr;
    logic       do_rdata;
    logic       wr_fire;
    logic       rd_fire;

    assign op       = din[9:8];
    assign do_waddr = rx_valid && (op == 2'b00);
    assign do_wdata = rx_valid && (op == 2'b01);
    assign do_raddr = rx_valid && (op == 2'b10);
    assign do_rdata = rx_valid && (op == 2'b11);
    assign wr_fire  = do_wdata && wr_armed;
    assign rd_fire  = do_rdata && (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (do_raddr) state_nxt = RADDR;
            end
            RADDR: begin
                if (do_raddr)      state_nxt = RADDR;
                else if (do_rdata) state_nxt = RDATA;
            end
            RDATA: begin
                // any cycle without a fresh 11 falls back to holding the address
                if (do_rdata) state_nxt = RDATA;
                else          state_nxt = RADDR;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign tx_valid = (state == RDATA);

    always_ff @(posedge clk) begin
        if (rst) begin
            dout     <= 8'h00;
            cmd_err  <= 1'b0;
            wr_addr  <= '0;
            rd_addr  <= '0;
            wr_armed <= 1'b0;
        end else begin
            cmd_err <= (do_wdata && !wr_armed) || (do_rdata && (state == IDLE));
            if (do_waddr) begin
                wr_addr  <= din[ADDR_SIZE-1:0];
                wr_armed <= 1'b1;
            end
`ifdef RAM_AUTOINC_EN
            else if (wr_fire) begin
                wr_addr <= wr_addr + 1'b1;
            end
`endif
            if (do_raddr) begin
                rd_addr <= din[ADDR_SIZE-1:0];
            end
`ifdef RAM_AUTOINC_EN
            else if (rd_fire) begin
                rd_addr <= rd_addr + 1'b1;
            end
`endif
            if (rd_fire) begin
                dout <= mem[rd_addr];
            end
        end
    end

    // storage is deliberately outside reset so contents survive it
    always_ff @(posedge clk) begin
        if (!rst && wr_fire) begin
            mem[wr_addr] <= din[7:0];
        end
    end

endmodule

// File: tb/tb_ram_cmd_ctrl.sv
// Randomized plus directed bench for ram_cmd_ctrl against a command-level reference model.
module tb_ram_cmd_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] din;
    logic       rx_valid;
    logic [7:0] dout;
    logic       tx_valid;
    logic       cmd_err;

    int errors = 0;
    int checks = 0;

    ram_cmd_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .rx_valid (rx_valid),
        .dout     (dout),
        .tx_valid (tx_valid),
        .cmd_err  (cmd_err)
    );

    always #5 clk = ~clk;

    // reference model: state of the command protocol, not of the FSM
    logic [7:0] m_mem [256];
    logic [7:0] m_wa;
    logic [7:0] m_ra;
    bit         m_armed;
    bit         m_have_ra;
    logic [7:0] exp_dout;
    bit         exp_tx;
    bit         exp_err;
    bit         chk_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            exp_dout  = 8'h00;
            exp_tx    = 1'b0;
            exp_err   = 1'b0;
            m_wa      = 8'h00;
            m_ra      = 8'h00;
            m_armed   = 1'b0;
            m_have_ra = 1'b0;
        end else begin
            exp_tx  = 1'b0;
            exp_err = 1'b0;
            if (rx_valid) begin
                case (din[9:8])
                    2'b00: begin
                        m_wa    = din[7:0];
                        m_armed = 1'b1;
                    end
                    2'b01: begin
                        if (m_armed) begin
                            m_mem[m_wa] = din[7:0];
`ifdef RAM_AUTOINC_EN
                            m_wa = 8'((int'(m_wa) + 1) % 256);
`endif
                        end else begin
                            exp_err = 1'b1;
                        end
                    end
                    2'b10: begin
                        m_ra      = din[7:0];
                        m_have_ra = 1'b1;
                    end
                    default: begin
                        if (m_have_ra) begin
                            exp_dout = m_mem[m_ra];
                            exp_tx   = 1'b1;
`ifdef RAM_AUTOINC_EN
                            m_ra = 8'((int'(m_ra) + 1) % 256);
`endif
                        end else begin
                            exp_err = 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("dout", dout, exp_dout);
            check("tx_valid", {7'd0, tx_valid}, {7'd0, exp_tx});
            check("cmd_err", {7'd0, cmd_err}, {7'd0, exp_err});
        end
    end

    task automatic drive(input bit r, input bit v, input logic [1:0] op, input logic [7:0] d);
        rst      = r;
        rx_valid = v;
        din      = {op, d};
        @(negedge clk);
    endtask

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        din      = 10'd0;
        @(negedge clk);
        drive(1'b1, 1'b0, 2'b00, 8'h00);
        chk_en = 1'b1;
        check("rst_dout", dout, 8'h00);
        check("rst_tx", {7'd0, tx_valid}, 8'h00);
        check("rst_err", {7'd0, cmd_err}, 8'h00);

        // fill every location so all later reads are defined
        for (int i = 0; i < 256; i++) begin
            drive(1'b0, 1'b1, 2'b00, 8'(i));
            drive(1'b0, 1'b1, 2'b01, 8'(i) ^ 8'h5A);
        end

        // write then read back through a single address
        drive(1'b1, 1'b0, 2'b00, 8'h00);
        drive(1'b0, 1'b1, 2'b00, 8'h3A);
        drive(1'b0, 1'b1, 2'b01, 8'hA5);
        drive(1'b0, 1'b1, 2'b10, 8'h3A);
        check("wr_rd_tx_before", {7'd0, tx_valid}, 8'h00);
        drive(1'b0, 1'b1, 2'b11, 8'h00);
        check("wr_rd_dout", dout, 8'hA5);
        check("wr_rd_tx", {7'd0, tx_valid}, 8'h01);
        drive(1'b0, 1'b0, 2'b00, 8'h00);
        check("wr_rd_tx_drop", {7'd0, tx_valid}, 8'h00);
        check("wr_rd_dout_hold", dout, 8'hA5);

        // sequence violations straight after reset
        drive(1'b1, 1'b0, 2'b00, 8'h00);
        drive(1'b0, 1'b1, 2'b11, 8'h00);
        check("rd_idle_err", {7'd0, cmd_err}, 8'h01);
        check("rd_idle_tx", {7'd0, tx_valid}, 8'h00);
        check("rd_idle_dout", dout, 8'h00);
        drive(1'b0, 1'b1, 2'b01, 8'h55);
        check("wr_unarmed_err", {7'd0, cmd_err}, 8'h01);
        drive(1'b0, 1'b0, 2'b00, 8'h00);
        check("err_one_cycle", {7'd0, cmd_err}, 8'h00);
        drive(1'b0, 1'b1, 2'b10, 8'h00);
        drive(1'b0, 1'b1, 2'b11, 8'h00);
        check("wr_unarmed_mem", dout, 8'h5A);

`ifdef RAM_AUTOINC_EN
        drive(1'b0, 1'b1, 2'b00, 8'hFF);
        drive(1'b0, 1'b1, 2'b01, 8'h11);
        drive(1'b0, 1'b1, 2'b01, 8'h22);
        drive(1'b0, 1'b1, 2'b10, 8'hFF);
        drive(1'b0, 1'b1, 2'b11, 8'h00);
        check("autoinc_dout0", dout, 8'h11);
        check("autoinc_tx0", {7'd0, tx_valid}, 8'h01);
        drive(1'b0, 1'b1, 2'b11, 8'h00);
        check("autoinc_dout1", dout, 8'h22);
        check("autoinc_tx1", {7'd0, tx_valid}, 8'h01);
`else
        drive(1'b0, 1'b1, 2'b00, 8'h10);
        drive(1'b0, 1'b1, 2'b01, 8'h11);
        drive(1'b0, 1'b1, 2'b01, 8'h22);
        drive(1'b0, 1'b1, 2'b10, 8'h10);
        drive(1'b0, 1'b1, 2'b11, 8'h00);
        check("noinc_dout", dout, 8'h22);
        drive(1'b0, 1'b1, 2'b11, 8'h00);
        check("noinc_b2b_dout", dout, 8'h22);
        check("noinc_b2b_tx", {7'd0, tx_valid}, 8'h01);
`endif

        // reset beats a simultaneous armed write, and drops tx_valid out of RDATA
        drive(1'b0, 1'b1, 2'b00, 8'h40);
        drive(1'b0, 1'b1, 2'b01, 8'h33);
        drive(1'b0, 1'b1, 2'b10, 8'h40);
        drive(1'b0, 1'b1, 2'b11, 8'h00);
        drive(1'b0, 1'b1, 2'b00, 8'h40);
        drive(1'b1, 1'b1, 2'b01, 8'h77);
        check("rst_wr_dout", dout, 8'h00);
        check("rst_wr_tx", {7'd0, tx_valid}, 8'h00);
        check("rst_wr_err", {7'd0, cmd_err}, 8'h00);
        drive(1'b0, 1'b1, 2'b10, 8'h40);
        drive(1'b0, 1'b1, 2'b11, 8'h00);
        check("rst_wr_mem", dout, 8'h33);

        // random traffic against the model
        for (int n = 0; n < 4000; n++) begin
            drive(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 3) != 0),
                  2'($urandom_range(0, 3)),
                  8'($urandom_range(0, 255)));
        end
        drive(1'b0, 1'b0, 2'b00, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_cmd_ctrl.md
RAM_CMD_CTRL -- requirements
Module: ram_cmd_ctrl

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 256, number of 8-bit words in the single-port memory.
REQ-002 SHALL have parameter ADDR_SIZE, default 8, address width; MEM_DEPTH = 2**ADDR_SIZE.
REQ-003 SHALL have port clk  input  1  the single clock; all logic samples on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port din  input  10  command word from the SPI slave: [9:8] opcode, [7:0] address or data.
REQ-006 SHALL have port rx_valid  input  1  din is valid this cycle, at most one command per cycle.
REQ-007 SHALL have port dout  output  8  read data returned to the SPI slave tx_data.
REQ-008 SHALL have port tx_valid  output  1  dout valid, one-cycle pulse per serviced read.
REQ-009 SHALL have port cmd_err  output  1  one-cycle pulse on a sequence violation.

Function
REQ-010 SHALL ignore din entirely in any cycle where rx_valid=0.
REQ-011 On opcode 00 (write address) SHALL load wr_addr <= din[ADDR_SIZE-1:0] and set wr_armed=1.
REQ-012 On opcode 01 (write data) with wr_armed=1 SHALL write mem[wr_addr] <= din[7:0] at that clock edge.
REQ-013 On opcode 01 with wr_armed=0 SHALL perform no write and pulse cmd_err in the next cycle.
REQ-014 On opcode 10 (read address) SHALL load rd_addr <= din[ADDR_SIZE-1:0] and move the read FSM to RADDR.
REQ-015 The read FSM SHALL have states IDLE (no read address), RADDR (address held) and RDATA (output cycle).
REQ-016 FSM transitions SHALL be: IDLE -10-> RADDR; RADDR -11-> RDATA; RDATA -no 11-> RADDR; RDATA -11-> RDATA; any state -10-> RADDR.
REQ-017 On opcode 11 (read data) in RADDR or RDATA SHALL register dout <= mem[rd_addr] and assert tx_valid=1 in the next cycle; latency is exactly 1 clock.
REQ-018 On opcode 11 in IDLE SHALL leave dout unchanged, keep tx_valid=0 and pulse cmd_err in the next cycle.
REQ-019 tx_valid SHALL equal 1 only while the FSM is in RDATA.
REQ-020 dout SHALL hold its last value between reads.
REQ-021 Back-to-back 11 commands SHALL each produce a fresh dout with tx_valid held high across both cycles.
REQ-022 Opcode 00 followed by 01 at the same address SHALL make the new data visible to a 10/11 sequence immediately after.
REQ-023 Address arithmetic SHALL be modulo MEM_DEPTH; an increment past MEM_DEPTH-1 SHALL wrap to 0.
REQ-024 cmd_err SHALL be a registered pulse, high exactly one cycle per violating command.

Reset
REQ-025 With rst=1 at a clock edge, SHALL set dout=0, tx_valid=0, cmd_err=0, wr_addr=0, rd_addr=0, wr_armed=0 and FSM=IDLE.
REQ-026 rst SHALL take priority over a simultaneous rx_valid; that command is discarded and memory is not written.
REQ-027 Memory contents SHALL NOT be cleared by reset.
REQ-028 A reset asserted during RDATA SHALL drop tx_valid in the following cycle.

Configuration
REQ-029 Macro RAM_AUTOINC_EN defined: each serviced 01 SHALL increment wr_addr and each serviced 11 SHALL increment rd_addr, with wrap per REQ-023.
REQ-030 Macro RAM_AUTOINC_EN undefined: wr_addr and rd_addr SHALL change only on opcodes 00 and 10.

Verification
REQ-031 rst, then 000x3A, 01xA5, 100x3A, 11x00 -> tx_valid pulse with dout=0xA5, 1 cycle after the 11 command.
REQ-032 After reset, 11x00 -> cmd_err pulse, tx_valid=0, dout=0; then 01x55 -> cmd_err pulse and mem unchanged.
REQ-033 RAM_AUTOINC_EN: 00xFF, 01x11, 01x22, 10xFF, 11, 11 -> dout 0x11 then 0x22 (address 0x00 after wrap), tx_valid high 2 cycles.
REQ-034 Without RAM_AUTOINC_EN: 00x10, 01x11, 01x22, 10x10, 11 -> dout=0x22.
REQ-035 rst asserted in the same cycle as a 01x77 to a written address -> location keeps its old value, all outputs 0 next cycle.
